input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Upstream conditioning stage for the DE10-Nano push-buttons and slide switches.
- Synchronises raw asynchronous pin levels into clk, applies per-bit polarity correction, and filters contact bounce per channel.
- Presents clean levels plus one-cycle change strobes to the user-input interrupt device.
- Channel packing is {keys[1:0], switches[3:0]}; keys are active-low on the board.

Parameters:
- WIDTH, 6, number of input channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range >= 1.
- INVERT_MASK, 6'b110000, per-bit XOR applied to raw_in before synchronisation (1 = pin is active-low).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- raw_in  input  WIDTH  unsynchronised pin levels.
- debounced  output  WIDTH  filtered, polarity-corrected levels.
- changed  output  WIDTH  one-cycle strobe per bit when that bit of debounced toggles.
- any_changed  output  1  OR-reduction of changed, registered with it.
- settled  output  1  high once the post-reset initial-acquisition window has elapsed.

Behaviour:
- Reset is asynchronous and active-high.
  - While reset is high, clear both sync stages, all per-channel counters, debounced, changed, any_changed, settled and the settle counter to 0.
  - Assertion mid-operation clears state immediately. Pending counts are discarded.
- Polarity and synchronisation:
  - in_c = raw_in ^ INVERT_MASK.
  - Two-flop synchroniser per bit: sync1 <= in_c, sync2 <= sync1.
- Per-channel filter, counter width = clog2(DEBOUNCE_CYCLES+1). Each rising edge, per bit i:
  - sync2[i] == debounced[i]: cnt[i] <= 0.
  - else cnt[i] == DEBOUNCE_CYCLES-1: debounced[i] <= sync2[i], cnt[i] <= 0, change event for bit i.
  - else: cnt[i] <= cnt[i] + 1.
  - Channels are fully independent; simultaneous events on several bits are all reported in the same cycle.
- Latency:
  - A level held stable at the pin updates debounced[i] on edge DEBOUNCE_CYCLES+2.
  - Edge 1 is the edge that first captures the new level into sync1.
- Glitch rejection: any return of sync2[i] to debounced[i] before the count completes clears cnt[i]. No change results, and the next deviation restarts the count from 0.
- changed[i] timing:
  - Registered, high for exactly the one cycle following the edge that updated debounced[i].
  - any_changed = OR of the same-cycle changed bits.
- Settle window:
  - Settle counter runs from reset deassertion and saturates at SETTLE = DEBOUNCE_CYCLES+3.
  - settled goes high on the edge the count reaches SETTLE and stays high until the next reset.
  - While settled == 0, changed and any_changed are forced to 0; debounced still updates, so initial switch positions are acquired silently.
  - The first change event reported is therefore a genuine post-power-up user action.
- No wrap-around: per-channel counters never exceed DEBOUNCE_CYCLES-1, and the settle counter saturates.

Test Plan (bench uses DEBOUNCE_CYCLES=4, INVERT_MASK=6'b110000):
- Reset with raw_in=6'b110000 held.
  - Required: all outputs 0 during reset.
  - After release: debounced stays 6'b000000, settled rises on the 7th edge after release, changed never pulses.
- Reset with raw_in=6'b110101.
  - Required: debounced becomes 6'b000101 on edge 6 after release, changed stays 0 (settled=0), settled=1 on edge 7.
- After settle, drive raw_in[0] 0->1 and hold.
  - Required: debounced[0]=1 exactly 6 edges after first capture, changed=6'b000001 and any_changed=1 for one cycle.
- Bounce raw_in[1] high for 3 cycles, low 1, high for 3 cycles, then low.
  - Required: debounced[1] never changes, changed stays 0.
- Press key0 (raw_in[4] 1->0) and flip switch2 on the same edge.
  - Required: debounced[4] and debounced[2] update on the same edge, changed=6'b010100 for one cycle.
- Assert reset asynchronously (between clock edges) while cnt[3]=2 with a pending change.
  - Required: outputs clear immediately, no changed pulse after release, settle window restarts.

Source files
------------

// File: rtl/input_debouncer.sv
// input_debouncer
//   Conditioning stage for board push-buttons and slide switches. Each raw
//   pin is first polarity-corrected, so that active-low keys read as 1 when
//   pressed. It is then brought into clk through a two-flop synchroniser and
//   filtered per channel. A channel accepts a new level only after the
//   synchronised value has differed from the current debounced level for
//   DEBOUNCE_CYCLES consecutive cycles. One-cycle change strobes are
//   suppressed until a post-reset settle window has elapsed. During that
//   window the initial switch positions are acquired silently.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   raw_in       unsynchronised pin levels, packed {keys[1:0], switches[3:0]}
//   debounced    filtered, polarity-corrected levels
//   changed      one-cycle strobe per bit when that debounced bit toggles
//   any_changed  OR of changed, registered alongside it
//   settled      high once the initial-acquisition window has elapsed
module input_debouncer #(
  parameter int                 WIDTH           = 6,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0]   INVERT_MASK     = 6'b110000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] changed,
  output logic             any_changed,
  output logic             settled
);

  localparam int CNT_W    = (DEBOUNCE_CYCLES + 1 > 2) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int SETTLE   = DEBOUNCE_CYCLES + 3;
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(SETTLE);

  logic [WIDTH-1:0]    sync1_reg;
  logic [WIDTH-1:0]    sync2_reg;
  logic [WIDTH-1:0]    event_next;
  logic [SETTLE_W-1:0] settle_cnt_reg;
  logic [WIDTH-1:0]    changed_reg;
  logic                any_changed_reg;
  logic                settled_reg;

  // Polarity correction happens ahead of the synchroniser, so every later
  // stage works in "1 = active" terms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in ^ INVERT_MASK;
      sync2_reg <= sync1_reg;
    end
  end

  // Independent filter per channel. A channel's counter only advances while
  // sync2 disagrees with its debounced level. Any agreement discards the
  // partial count, so a glitch restarts the qualification from zero.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic             deb_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
          deb_reg <= 1'b0;
        end else if (sync2_reg[gi] == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          deb_reg <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      // True on exactly the edge that flips deb_reg.
      assign event_next[gi] = (sync2_reg[gi] != deb_reg) && (cnt_reg == CNT_LAST);
      assign debounced[gi]  = deb_reg;
    end
  endgenerate

  // The settle counter starts from reset release and saturates at SETTLE.
  // settled rises on the edge where the count reaches SETTLE. Strobes are
  // gated by the registered settled value, so an event on the same edge that
  // settled rises is still treated as part of the initial acquisition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt_reg  <= '0;
      settled_reg     <= 1'b0;
      changed_reg     <= '0;
      any_changed_reg <= 1'b0;
    end else begin
      if (settle_cnt_reg != SETTLE_MAX) begin
        settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
      end
      if (settle_cnt_reg == SETTLE_LAST) begin
        settled_reg <= 1'b1;
      end
      changed_reg     <= settled_reg ? event_next : '0;
      any_changed_reg <= settled_reg & (|event_next);
    end
  end

  assign changed     = changed_reg;
  assign any_changed = any_changed_reg;
  assign settled     = settled_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4 and
// INVERT_MASK=6'b110000. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at the same point, so "edge k" means the k-th rising
// edge after the change.
module tb_input_debouncer;

  logic       clk;
  logic       reset;
  logic [5:0] raw_in;
  logic [5:0] debounced;
  logic [5:0] changed;
  logic       any_changed;
  logic       settled;

  int total;
  int bad;

  input_debouncer #(
    .WIDTH           (6),
    .DEBOUNCE_CYCLES (4),
    .INVERT_MASK     (6'b110000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_in      (raw_in),
    .debounced   (debounced),
    .changed     (changed),
    .any_changed (any_changed),
    .settled     (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".debounced"}, debounced, 6'b000000);
    check({tag, ".changed"}, changed, 6'b000000);
    check({tag, ".any_changed"}, {5'b0, any_changed}, 6'b000000);
    check({tag, ".settled"}, {5'b0, settled}, 6'b000000);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    raw_in = 6'b110000;

    // 1) Reset with idle pins: nothing is acquired, and no strobe fires.
    tick();
    tick();
    check_all_zero("rst_idle");
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("idle_deb_e%0d", k), debounced, 6'b000000);
      check($sformatf("idle_chg_e%0d", k), changed, 6'b000000);
      check($sformatf("idle_set_e%0d", k), {5'b0, settled}, (k >= 7) ? 6'b000001 : 6'b000000);
    end

    // 2) Reset with switches 0 and 2 on: acquired on edge 6, silently.
    reset  = 1'b1;
    raw_in = 6'b110101;
    tick();
    check_all_zero("rst_sw");
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("acq_deb_e%0d", k), debounced, (k >= 6) ? 6'b000101 : 6'b000000);
      check($sformatf("acq_chg_e%0d", k), changed, 6'b000000);
      check($sformatf("acq_any_e%0d", k), {5'b0, any_changed}, 6'b000000);
      check($sformatf("acq_set_e%0d", k), {5'b0, settled}, (k >= 7) ? 6'b000001 : 6'b000000);
    end

    // 3) Return switch 0 low and let it settle, then drive it 0->1.
    raw_in = 6'b110100;
    for (int k = 1; k <= 8; k++) tick();
    check("sw0_low_deb", debounced, 6'b000100);
    check("sw0_low_chg", changed, 6'b000000);
    raw_in = 6'b110101;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("sw0_deb_e%0d", k), debounced, (k >= 6) ? 6'b000101 : 6'b000100);
      check($sformatf("sw0_chg_e%0d", k), changed, (k == 6) ? 6'b000001 : 6'b000000);
      check($sformatf("sw0_any_e%0d", k), {5'b0, any_changed}, (k == 6) ? 6'b000001 : 6'b000000);
    end

    // 4) Bounce switch 1: the bursts are too short, so nothing is accepted.
    for (int k = 1; k <= 14; k++) begin
      if (k == 1 || k == 5) raw_in = 6'b110111;
      if (k == 4 || k == 8) raw_in = 6'b110101;
      tick();
      check($sformatf("bnc_deb_e%0d", k), debounced, 6'b000101);
      check($sformatf("bnc_chg_e%0d", k), changed, 6'b000000);
    end

    // 5) Key0 press (raw[4] 1->0) and switch 2 off on the same edge.
    raw_in = 6'b100001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("dual_deb_e%0d", k), debounced, (k >= 6) ? 6'b010001 : 6'b000101);
      check($sformatf("dual_chg_e%0d", k), changed, (k == 6) ? 6'b010100 : 6'b000000);
      check($sformatf("dual_any_e%0d", k), {5'b0, any_changed}, (k == 6) ? 6'b000001 : 6'b000000);
    end

    // 6) Switch 3 on. Reset asynchronously once its count has reached 2.
    raw_in = 6'b101001;
    for (int k = 1; k <= 4; k++) tick();
    check("pend_deb", debounced, 6'b010001);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    check_all_zero("async_rst_held");
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("rel_deb_e%0d", k), debounced, (k >= 6) ? 6'b011001 : 6'b000000);
      check($sformatf("rel_chg_e%0d", k), changed, 6'b000000);
      check($sformatf("rel_any_e%0d", k), {5'b0, any_changed}, 6'b000000);
      check($sformatf("rel_set_e%0d", k), {5'b0, settled}, (k >= 7) ? 6'b000001 : 6'b000000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
